chip8_video_mux: RTL and testbench

CHIP8_VIDEO_MUX -- requirements
Module: chip8_video_mux

---
 rtl/chip8_video_mux.sv | 183 ++++++++++++++++++
 tb/tb_chip8_video_mux.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_video_mux.sv
// CHIP-8 framebuffer video mux: maps 1280x720 raster coordinates onto one of up to four
// scaled CHIP-8 framebuffers (single or 2x2 quad layout), fetches the VRAM byte and emits the pixel.
module chip8_video_mux #(
    parameter int NUM_CH       = 4,
    parameter int SCALE_SHIFT  = 4,
    parameter int BRAM_LATENCY = 2,
    parameter int H_OFF        = 128,
    parameter int V_OFF        = 104,
    parameter int Q_H_OFF      = 64,
    parameter int Q_V_OFF      = 52
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              active_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              mode_in,
    input  logic [1:0]        sel_in,
    input  logic [NUM_CH-1:0] hires_in,
    input  logic [7:0]        hdmi_data_in,
    output logic [15:0]       hdmi_addr_out,
    output logic [1:0]        vram_ch_out,
    output logic              hdmi_pixel_out,
    output logic              in_window_out,
    output logic [1:0]        ch_out,
    output logic              active_out,
    output logic              hsync_out,
    output logic              vsync_out
);

    localparam int SPAN_X_S = 64 << SCALE_SHIFT;
    localparam int SPAN_Y_S = 32 << SCALE_SHIFT;
    localparam int SPAN_X_Q = 64 << (SCALE_SHIFT - 1);
    localparam int SPAN_Y_Q = 32 << (SCALE_SHIFT - 1);

    typedef struct packed {
        logic [2:0] bitsel;
        logic       win;
        logic [1:0] ch;
        logic       act;
        logic       hs;
        logic       vs;
    } side_t;

    logic              mode_q, mode_d;
    logic [1:0]        sel_q, sel_d;
    logic [NUM_CH-1:0] hires_q, hires_d;
    logic [15:0]       addr_q, addr_d;
    logic [1:0]        vram_ch_q, vram_ch_d;
    side_t             side_q [BRAM_LATENCY+1];
    side_t             side_d [BRAM_LATENCY+1];
    logic              pixel_q, pixel_d;
    logic              win_q, win_d;
    logic [1:0]        ch_q, ch_d;
    logic              act_q, act_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;

    logic        quad;
    logic [1:0]  quadrant;
    logic [1:0]  ch;
    logic [3:0]  hires_pad;
    logic        hr;
    logic [11:0] org_x;
    logic [10:0] org_y;
    logic [11:0] dx;
    logic [10:0] dy;
    logic [6:0]  xs;
    logic [5:0]  ys;
    logic        win;
    int          shift;
    int          span_x;
    int          span_y;
    side_t       tail;

    always_comb begin
        mode_d  = mode_q;
        sel_d   = sel_q;
        hires_d = hires_q;
        if (hcount_in == 11'd0 && vcount_in == 10'd0) begin
            mode_d  = (NUM_CH > 1) ? mode_in : 1'b0;
            sel_d   = (NUM_CH > 1) ? sel_in : 2'd0;
            hires_d = hires_in;
        end

        // Stage 0: screen position -> framebuffer coordinate
        quad      = mode_q;
        quadrant  = {vcount_in >= 10'd360, hcount_in >= 11'd640};
        ch        = quad ? quadrant : sel_q;
        hires_pad = 4'(hires_q);
        hr        = hires_pad[ch];
        if (quad) begin
            org_x = (quadrant[0] ? 12'd640 : 12'd0) + 12'(Q_H_OFF);
            org_y = (quadrant[1] ? 11'd360 : 11'd0) + 11'(Q_V_OFF);
        end else begin
            org_x = 12'(H_OFF);
            org_y = 11'(V_OFF);
        end
        dx     = {1'b0, hcount_in} - org_x;
        dy     = {1'b0, vcount_in} - org_y;
        shift  = SCALE_SHIFT - int'(quad) - int'(hr);
        span_x = quad ? SPAN_X_Q : SPAN_X_S;
        span_y = quad ? SPAN_Y_Q : SPAN_Y_S;
        xs     = 7'(dx[10:0] >> shift);
        ys     = 6'(dy[9:0] >> shift);
        // The sign bits catch origin underflow before the span compare sees a wrapped value
        win    = !dx[11] && !dy[10] && (int'(dx) < span_x) && (int'(dy) < span_y)
                 && (int'(ch) < NUM_CH);

        addr_d    = 16'd0;
        vram_ch_d = vram_ch_q;
        if (win) begin
            addr_d    = hr ? {6'd0, ys[5:0], xs[6:3]} : {8'd0, ys[4:0], xs[5:3]};
            vram_ch_d = ch;
        end

        // Stage 1..BRAM_LATENCY+1: sideband rides alongside the VRAM read
        side_d[0].bitsel = xs[2:0];
        side_d[0].win    = win;
        side_d[0].ch     = ch;
        side_d[0].act    = active_in;
        side_d[0].hs     = hsync_in;
        side_d[0].vs     = vsync_in;
        for (int i = 1; i <= BRAM_LATENCY; i++) begin
            side_d[i] = side_q[i-1];
        end

        // Final stage: pick the pixel bit out of the returned byte
        tail    = side_q[BRAM_LATENCY];
        pixel_d = tail.win & hdmi_data_in[tail.bitsel];
        win_d   = tail.win;
        ch_d    = tail.ch;
        act_d   = tail.act;
        hs_d    = tail.hs;
        vs_d    = tail.vs;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mode_q    <= 1'b0;
            sel_q     <= 2'd0;
            hires_q   <= '0;
            addr_q    <= 16'd0;
            vram_ch_q <= 2'd0;
            for (int i = 0; i <= BRAM_LATENCY; i++) begin
                side_q[i] <= '0;
            end
            pixel_q   <= 1'b0;
            win_q     <= 1'b0;
            ch_q      <= 2'd0;
            act_q     <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            sel_q     <= sel_d;
            hires_q   <= hires_d;
            addr_q    <= addr_d;
            vram_ch_q <= vram_ch_d;
            for (int i = 0; i <= BRAM_LATENCY; i++) begin
                side_q[i] <= side_d[i];
            end
            pixel_q   <= pixel_d;
            win_q     <= win_d;
            ch_q      <= ch_d;
            act_q     <= act_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
        end
    end

    assign hdmi_addr_out  = addr_q;
    assign vram_ch_out    = vram_ch_q;
    assign hdmi_pixel_out = pixel_q;
    assign in_window_out  = win_q;
    assign ch_out         = ch_q;
    assign active_out     = act_q;
    assign hsync_out      = hs_q;
    assign vsync_out      = vs_q;

endmodule

// File: tb/tb_chip8_video_mux.sv
// Scoreboard bench for chip8_video_mux: a behavioural VRAM feeds the DUT, and expected
// address/pixel/timing values are computed from screen geometry and queued per driven pixel.
module tb_chip8_video_mux;

    localparam int BL = 2;
    localparam int L  = BL + 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        active_in, hsync_in, vsync_in, mode_in;
    logic [1:0]  sel_in;
    logic [3:0]  hires_in;
    logic [7:0]  hdmi_data_in;
    logic [15:0] hdmi_addr_out;
    logic [1:0]  vram_ch_out;
    logic        hdmi_pixel_out, in_window_out;
    logic [1:0]  ch_out;
    logic        active_out, hsync_out, vsync_out;

    chip8_video_mux dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .active_in     (active_in),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .mode_in       (mode_in),
        .sel_in        (sel_in),
        .hires_in      (hires_in),
        .hdmi_data_in  (hdmi_data_in),
        .hdmi_addr_out (hdmi_addr_out),
        .vram_ch_out   (vram_ch_out),
        .hdmi_pixel_out(hdmi_pixel_out),
        .in_window_out (in_window_out),
        .ch_out        (ch_out),
        .active_out    (active_out),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Behavioural VRAM with BL cycles of read latency
    logic [7:0] mem [4][1024];
    logic [7:0] rd_pipe [BL];
    always @(posedge clk_in) begin
        rd_pipe[0] <= mem[vram_ch_out][hdmi_addr_out[9:0]];
        for (int i = 1; i < BL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign hdmi_data_in = rd_pipe[BL-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    typedef struct {
        int    due;
        int    addr;
        int    vch;
        string tag;
    } aent_t;

    typedef struct {
        int    due;
        int    pix;
        int    win;
        int    ch;
        bit    chk_ch;
        bit    act;
        bit    hs;
        bit    vs;
        string tag;
    } oent_t;

    aent_t addr_sb[$];
    oent_t out_sb[$];

    // Reference state: frame-latched controls and last in-window VRAM channel
    bit       cur_mode, m_mode;
    bit [1:0] cur_sel, m_sel;
    bit [3:0] cur_hires, m_hires;
    int       last_vch;

    task automatic drive_px(input int h, input int v, input bit a, input bit hs, input bit vs,
                            input string tag, input int xa = -1, input int xp = -1,
                            input int xc = -1);
        bit    quad, in;
        int    ch, ox, oy, hr, psz, dx, dy, col, row, wide, ad, pix;
        aent_t ea;
        oent_t eo;
        @(posedge clk_in);
        #1;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        active_in = a;
        hsync_in  = hs;
        vsync_in  = vs;
        mode_in   = cur_mode;
        sel_in    = cur_sel;
        hires_in  = cur_hires;

        quad = m_mode;
        ch   = quad ? (((v >= 360) ? 2 : 0) + ((h >= 640) ? 1 : 0)) : int'(m_sel);
        ox   = quad ? (((h >= 640) ? 640 : 0) + 64) : 128;
        oy   = quad ? (((v >= 360) ? 360 : 0) + 52) : 104;
        hr   = int'(m_hires[ch]);
        psz  = (quad ? 8 : 16) / ((hr != 0) ? 2 : 1);
        dx   = h - ox;
        dy   = v - oy;
        in   = (dx >= 0) && (dy >= 0) && (dx < (quad ? 512 : 1024)) && (dy < (quad ? 256 : 512));
        col  = in ? dx / psz : 0;
        row  = in ? dy / psz : 0;
        wide = (hr != 0) ? 128 : 64;
        ad   = in ? (row * wide + col) / 8 : 0;
        pix  = in ? int'(mem[ch][ad][col % 8]) : 0;
        if (in) last_vch = ch;

        ea.due  = cyc + 1;
        ea.addr = (xa >= 0) ? xa : ad;
        ea.vch  = (xc >= 0) ? xc : last_vch;
        ea.tag  = tag;
        addr_sb.push_back(ea);

        eo.due    = cyc + L;
        eo.pix    = (xp >= 0) ? xp : pix;
        eo.win    = int'(in);
        eo.ch     = (xc >= 0) ? xc : ch;
        eo.chk_ch = in;
        eo.act    = a;
        eo.hs     = hs;
        eo.vs     = vs;
        eo.tag    = tag;
        out_sb.push_back(eo);

        if (h == 0 && v == 0) begin
            m_mode  = cur_mode;
            m_sel   = cur_sel;
            m_hires = cur_hires;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".addr"},  hdmi_addr_out, 0);
        check_eq({tag, ".vch"},   vram_ch_out, 0);
        check_eq({tag, ".pix"},   hdmi_pixel_out, 0);
        check_eq({tag, ".win"},   in_window_out, 0);
        check_eq({tag, ".ch"},    ch_out, 0);
        check_eq({tag, ".act"},   active_out, 0);
        check_eq({tag, ".hs"},    hsync_out, 0);
        check_eq({tag, ".vs"},    vsync_out, 0);
    endtask

    always @(negedge clk_in) begin
        if (rst_in) begin
            while (addr_sb.size() > 0 && addr_sb[0].due <= cyc) begin
                aent_t ea;
                ea = addr_sb.pop_front();
                if (ea.due != cyc) check_eq({ea.tag, ".late"}, cyc, ea.due);
                else begin
                    check_eq({ea.tag, ".addr"}, hdmi_addr_out, ea.addr);
                    check_eq({ea.tag, ".vch"}, vram_ch_out, ea.vch);
                end
            end
            while (out_sb.size() > 0 && out_sb[0].due <= cyc) begin
                oent_t eo;
                eo = out_sb.pop_front();
                if (eo.due != cyc) check_eq({eo.tag, ".late"}, cyc, eo.due);
                else begin
                    check_eq({eo.tag, ".pix"}, hdmi_pixel_out, eo.pix);
                    check_eq({eo.tag, ".win"}, in_window_out, eo.win);
                    if (eo.chk_ch) check_eq({eo.tag, ".ch"}, ch_out, eo.ch);
                    check_eq({eo.tag, ".act"}, active_out, eo.act);
                    check_eq({eo.tag, ".hs"}, hsync_out, eo.hs);
                    check_eq({eo.tag, ".vs"}, vsync_out, eo.vs);
                end
            end
        end
    end

    initial begin
        #300us;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    initial begin
        rst_in    = 1'b0;
        hcount_in = 11'd5;
        vcount_in = 10'd5;
        active_in = 1'b1;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        mode_in   = 1'b1;
        sel_in    = 2'd2;
        hires_in  = 4'hF;
        for (int i = 0; i < BL; i++) rd_pipe[i] = 8'h00;
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 1024; a++) mem[c][a] = 8'($urandom);
        for (int c = 0; c < 4; c++) mem[c][0] = 8'hFF;
        mem[0][25]  = 8'h02;
        mem[0][642] = 8'h10;
        mem[3][255] = 8'h80;
        cur_mode = 0; cur_sel = 0; cur_hires = 0;
        m_mode = 0; m_sel = 0; m_hires = 0; last_vch = 0;

        idle(3);
        #1;
        check_all_zero("reset");
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;

        // Single lores frame
        drive_px(0, 0, 0, 1, 1, "f0");
        drive_px(272, 152, 1, 0, 0, "r35", 25, 1, 0);
        drive_px(127, 104, 1, 1, 0, "r38a", 0, 0);
        drive_px(1152, 104, 1, 0, 1, "r38b", 0, 0);

        // Single hires on channel 0
        cur_hires = 4'b0001;
        drive_px(0, 0, 0, 0, 0, "f1");
        drive_px(288, 424, 1, 0, 0, "r36a", 642, 1, 0);
        idle(L + 2);
        mem[0][642] = 8'hEF;
        drive_px(288, 424, 1, 1, 0, "r36b", 642, 0, 0);

        // Quad mode
        cur_mode = 1; cur_hires = 4'b0000;
        drive_px(0, 0, 0, 0, 0, "f2");
        drive_px(1208, 660, 1, 0, 0, "r37", 255, 1, 3);
        drive_px(650, 20, 1, 1, 1, "hold");
        drive_px(700, 100, 1, 0, 0, "q1");
        drive_px(100, 500, 1, 0, 0, "q2");

        // Mode change mid-frame takes effect only at the next frame start
        cur_mode = 0;
        drive_px(0, 0, 0, 0, 0, "f3");
        cur_mode = 1;
        drive_px(500, 300, 1, 0, 0, "r39a");
        drive_px(272, 152, 1, 0, 0, "r39pre", 25, 1, 0);
        drive_px(0, 0, 0, 0, 0, "f4");
        drive_px(272, 152, 1, 0, 0, "r39post", 99, -1, 0);

        // Random raster positions with occasional frame restarts
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                cur_mode  = 1'($urandom);
                cur_sel   = 2'($urandom);
                cur_hires = 4'($urandom);
                drive_px(0, 0, 0, 0, 0, "rnd.frame");
            end else begin
                drive_px($urandom_range(0, 1279), $urandom_range(0, 719),
                         1'($urandom), 1'($urandom), 1'($urandom), "rnd");
            end
        end

        // Asynchronous reset in the middle of a line
        drive_px(300, 200, 1, 1, 0, "pre_rst0");
        drive_px(301, 200, 1, 0, 1, "pre_rst1");
        drive_px(302, 200, 1, 1, 1, "pre_rst2");
        @(posedge clk_in);
        #3;
        rst_in = 1'b0;
        #1;
        check_all_zero("midrst");
        addr_sb.delete();
        out_sb.delete();
        m_mode = 0; m_sel = 0; m_hires = 0; last_vch = 0;
        cur_mode = 0; cur_sel = 0; cur_hires = 0;
        idle(2);
        #1;
        rst_in = 1'b1;
        for (int n = 0; n < 16; n++) begin
            drive_px(400 + n, 210, 1, 1'((n / 3) % 2), 1'(n == 7), "post_rst");
        end

        for (int i = 0; i < 40 && (addr_sb.size() + out_sb.size()) > 0; i++) @(posedge clk_in);
        @(negedge clk_in);
        check_eq("drain", addr_sb.size() + out_sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
